// File: rtl/cache_nway_pkg.sv
// rtl/cache_nway_pkg.sv - controller state type and line-field geometry helpers for the n-way cache
package cache_nway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_COMPARE,
        ST_WRITEBACK,
        ST_REFILL,
        ST_UPDATE,
        ST_RESPOND
    } state_t;

    function automatic int off_bits_f(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    function automatic int tag_bits_f(input int word_size, input int block_words, input int sets);
        return word_size - $clog2(sets) - off_bits_f(block_words);
    endfunction

    // Line layout MSB->LSB: {valid, dirty, age, tag, data}
    function automatic int line_w_f(input int word_size, input int block_words,
                                    input int ways, input int sets);
        return 2 + $clog2(ways) + tag_bits_f(word_size, block_words, sets) + block_words * word_size;
    endfunction

    function automatic int tag_lsb_f(input int word_size, input int block_words);
        return block_words * word_size;
    endfunction

    function automatic int age_lsb_f(input int word_size, input int block_words, input int sets);
        return tag_lsb_f(word_size, block_words) + tag_bits_f(word_size, block_words, sets);
    endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// rtl/cache_ctrl_nway_if.sv - cpu, tag/data array and memory buses of the n-way cache controller
interface cache_ctrl_nway_if #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int WAYS        = 4,
    parameter int SETS        = 128
);
    import cache_nway_pkg::*;

    localparam int SET_BITS = $clog2(SETS);
    localparam int BLOCK_W  = BLOCK_WORDS * WORD_SIZE;
    localparam int LINE_W   = line_w_f(WORD_SIZE, BLOCK_WORDS, WAYS, SETS);

    logic                     cpu_req_enable;
    logic                     cpu_req_rw;
    logic [WORD_SIZE-1:0]     cpu_req_addr;
    logic [WORD_SIZE-1:0]     cpu_req_datain;
    logic                     cpu_req_ready;
    logic                     cpu_res_ready;
    logic [WORD_SIZE-1:0]     cpu_res_dataout;

    logic                     cache_enable;
    logic                     cache_rw;
    logic [SET_BITS-1:0]      cache_set;
    logic                     cache_ready;
    logic [WAYS*LINE_W-1:0]   cache_rd_lines;
    logic [WAYS*LINE_W-1:0]   cache_wr_lines;
    logic [WAYS-1:0]          cache_wr_mask;

    logic                     mem_req_enable;
    logic                     mem_req_rw;
    logic [WORD_SIZE-1:0]     mem_req_addr;
    logic [BLOCK_W-1:0]       mem_req_dataout;
    logic [BLOCK_W-1:0]       mem_req_datain;
    logic                     mem_req_ready;

    modport master (
        input  cpu_req_enable, cpu_req_rw, cpu_req_addr, cpu_req_datain,
        output cpu_req_ready, cpu_res_ready, cpu_res_dataout,
        output cache_enable, cache_rw, cache_set, cache_wr_lines, cache_wr_mask,
        input  cache_ready, cache_rd_lines,
        output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        input  mem_req_datain, mem_req_ready
    );

    modport slave (
        output cpu_req_enable, cpu_req_rw, cpu_req_addr, cpu_req_datain,
        input  cpu_req_ready, cpu_res_ready, cpu_res_dataout,
        input  cache_enable, cache_rw, cache_set, cache_wr_lines, cache_wr_mask,
        output cache_ready, cache_rd_lines,
        input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        output mem_req_datain, mem_req_ready
    );

endinterface

// File: rtl/cache_way_select.sv
// rtl/cache_way_select.sv - combinational hit detect, victim choice and age-LRU update over one set
module cache_way_select #(
    parameter int WAYS     = 4,
    parameter int TAG_BITS = 19
) (
    input  logic [WAYS*(2+$clog2(WAYS)+TAG_BITS)-1:0] meta,
    input  logic [TAG_BITS-1:0]                       tag,
    output logic                                      hit,
    output logic [$clog2(WAYS)-1:0]                   hit_way,
    output logic [$clog2(WAYS)-1:0]                   victim_way,
    output logic                                      victim_dirty,
    output logic [$clog2(WAYS)-1:0]                   acc_way,
    output logic [WAYS*$clog2(WAYS)-1:0]              new_ages
);
    localparam int AGE_BITS = $clog2(WAYS);
    localparam int META_W   = 2 + AGE_BITS + TAG_BITS;
    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(WAYS - 1);

    logic                valid   [WAYS];
    logic                dirty   [WAYS];
    logic [AGE_BITS-1:0] age     [WAYS];
    logic [TAG_BITS-1:0] way_tag [WAYS];

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            {valid[i], dirty[i], age[i], way_tag[i]} = meta[i*META_W +: META_W];
        end
    end

    logic                found_free;
    logic [AGE_BITS-1:0] free_way;
    logic [AGE_BITS-1:0] oldest_way;
    logic [AGE_BITS-1:0] acc_age;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_free = 1'b0;
        free_way   = '0;
        oldest_way = '0;
        // Scanning downward leaves the lowest matching / invalid index in place.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[i] && way_tag[i] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_BITS'(i);
            end
            if (!valid[i]) begin
                found_free = 1'b1;
                free_way   = AGE_BITS'(i);
            end
        end
        for (int i = 1; i < WAYS; i++) begin
            if (age[i] > age[oldest_way]) oldest_way = AGE_BITS'(i);
        end
        victim_way   = found_free ? free_way : oldest_way;
        victim_dirty = valid[victim_way] && dirty[victim_way];
        acc_way      = hit ? hit_way : victim_way;
        acc_age      = hit ? age[hit_way] : AGE_MAX;
        for (int i = 0; i < WAYS; i++) begin
            if (AGE_BITS'(i) == acc_way)
                new_ages[i*AGE_BITS +: AGE_BITS] = '0;
            else if (age[i] < acc_age)
                new_ages[i*AGE_BITS +: AGE_BITS] = (age[i] == AGE_MAX) ? age[i] : age[i] + 1'b1;
            else
                new_ages[i*AGE_BITS +: AGE_BITS] = age[i];
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - n-way write-back write-allocate cache controller with age LRU and counters
module cache_ctrl_nway
    import cache_nway_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int WAYS        = 4,
    parameter int SETS        = 128
) (
    input  logic              clk,
    input  logic              rst,
    cache_ctrl_nway_if.master bus,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
);
    localparam int OFF_BITS   = off_bits_f(BLOCK_WORDS);
    localparam int SET_BITS   = $clog2(SETS);
    localparam int TAG_BITS   = tag_bits_f(WORD_SIZE, BLOCK_WORDS, SETS);
    localparam int AGE_BITS   = $clog2(WAYS);
    localparam int BLOCK_W    = BLOCK_WORDS * WORD_SIZE;
    localparam int LINE_W     = line_w_f(WORD_SIZE, BLOCK_WORDS, WAYS, SETS);
    localparam int META_W     = LINE_W - BLOCK_W;
    localparam int TAG_LSB    = tag_lsb_f(WORD_SIZE, BLOCK_WORDS);
    localparam int AGE_LSB    = age_lsb_f(WORD_SIZE, BLOCK_WORDS, SETS);
    localparam int DIRTY_BIT  = LINE_W - 2;
    localparam int WORD_IDX_W = OFF_BITS - 2;

    state_t state, state_next;

    logic                     req_rw;
    logic [WORD_SIZE-3:0]     req_addr;
    logic [WORD_SIZE-1:0]     req_data;
    logic [WAYS*LINE_W-1:0]   rd_lines;
    logic [BLOCK_W-1:0]       refill_data;
    logic [WORD_SIZE-1:0]     res_data;
    logic                     unused_addr_bits;

    logic [WORD_IDX_W-1:0]    word_idx;
    logic [SET_BITS-1:0]      req_set;
    logic [TAG_BITS-1:0]      req_tag;

    assign unused_addr_bits = ^bus.cpu_req_addr[1:0];
    assign word_idx = req_addr[WORD_IDX_W-1:0];
    assign req_set  = req_addr[WORD_IDX_W +: SET_BITS];
    assign req_tag  = req_addr[WORD_SIZE-3 -: TAG_BITS];

    logic [WAYS*META_W-1:0]   meta;
    logic                     hit, victim_dirty;
    logic [AGE_BITS-1:0]      hit_way, victim_way, acc_way;
    logic [WAYS*AGE_BITS-1:0] new_ages;

    always_comb begin
        for (int i = 0; i < WAYS; i++) meta[i*META_W +: META_W] = rd_lines[i*LINE_W + BLOCK_W +: META_W];
    end

    cache_way_select #(.WAYS(WAYS), .TAG_BITS(TAG_BITS)) u_sel (
        .meta         (meta),
        .tag          (req_tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .acc_way      (acc_way),
        .new_ages     (new_ages)
    );

    logic [LINE_W-1:0]        hit_line, acc_line;
    logic [BLOCK_W-1:0]       victim_data;
    logic [TAG_BITS-1:0]      victim_tag;
    logic [WAYS*LINE_W-1:0]   upd_lines;
    logic [WORD_SIZE-1:0]     res_word;

    // Accessed line is either the hit line or a fresh refill; every other way only gets its age rewritten.
    always_comb begin
        hit_line    = '0;
        victim_data = '0;
        victim_tag  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (AGE_BITS'(i) == hit_way) hit_line = rd_lines[i*LINE_W +: LINE_W];
            if (AGE_BITS'(i) == victim_way) begin
                victim_data = rd_lines[i*LINE_W +: BLOCK_W];
                victim_tag  = rd_lines[i*LINE_W + TAG_LSB +: TAG_BITS];
            end
        end
        acc_line = hit ? hit_line : {1'b1, req_rw, {AGE_BITS{1'b0}}, req_tag, refill_data};
        acc_line[AGE_LSB +: AGE_BITS] = '0;
        if (req_rw) begin
            acc_line[int'(word_idx)*WORD_SIZE +: WORD_SIZE] = req_data;
            acc_line[DIRTY_BIT] = 1'b1;
        end
        res_word  = acc_line[int'(word_idx)*WORD_SIZE +: WORD_SIZE];
        upd_lines = rd_lines;
        for (int i = 0; i < WAYS; i++) begin
            upd_lines[i*LINE_W + AGE_LSB +: AGE_BITS] = new_ages[i*AGE_BITS +: AGE_BITS];
            if (AGE_BITS'(i) == acc_way) upd_lines[i*LINE_W +: LINE_W] = acc_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next          = state;
        bus.cpu_req_ready   = 1'b0;
        bus.cpu_res_ready   = 1'b0;
        bus.cache_enable    = 1'b0;
        bus.cache_rw        = 1'b0;
        bus.cache_set       = '0;
        bus.cache_wr_lines  = '0;
        bus.cache_wr_mask   = '0;
        bus.mem_req_enable  = 1'b0;
        bus.mem_req_rw      = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_dataout = '0;
        case (state)
            ST_IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_enable) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                bus.cache_enable = 1'b1;
                bus.cache_set    = req_set;
                if (bus.cache_ready) state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (hit)               state_next = ST_UPDATE;
                else if (victim_dirty) state_next = ST_WRITEBACK;
                else                   state_next = ST_REFILL;
            end
            ST_WRITEBACK: begin
                bus.mem_req_enable  = 1'b1;
                bus.mem_req_rw      = 1'b1;
                bus.mem_req_addr    = {victim_tag, req_set, {OFF_BITS{1'b0}}};
                bus.mem_req_dataout = victim_data;
                if (bus.mem_req_ready) state_next = ST_REFILL;
            end
            ST_REFILL: begin
                bus.mem_req_enable = 1'b1;
                bus.mem_req_addr   = {req_tag, req_set, {OFF_BITS{1'b0}}};
                if (bus.mem_req_ready) state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                bus.cache_enable   = 1'b1;
                bus.cache_rw       = 1'b1;
                bus.cache_set      = req_set;
                bus.cache_wr_lines = upd_lines;
                bus.cache_wr_mask  = '1;
                if (bus.cache_ready) state_next = ST_RESPOND;
            end
            ST_RESPOND: begin
                bus.cpu_res_ready = 1'b1;
                state_next        = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.cpu_res_dataout = res_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_rw      <= 1'b0;
            req_addr    <= '0;
            req_data    <= '0;
            rd_lines    <= '0;
            refill_data <= '0;
            res_data    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            wb_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.cpu_req_enable) begin
                    req_rw   <= bus.cpu_req_rw;
                    req_addr <= bus.cpu_req_addr[WORD_SIZE-1:2];
                    req_data <= bus.cpu_req_datain;
                end
                ST_LOOKUP: if (bus.cache_ready) rd_lines <= bus.cache_rd_lines;
                ST_COMPARE: begin
                    if (hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 32'd1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        if (victim_dirty && wb_count != '1) wb_count <= wb_count + 32'd1;
                    end
                end
                ST_REFILL: if (bus.mem_req_ready) refill_data <= bus.mem_req_datain;
                ST_UPDATE: if (bus.cache_ready) res_data <= res_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed self-checking bench for cache_ctrl_nway (4-way and 8-way builds)
module tb_cache_ctrl_nway;
    localparam int L4 = 535;
    localparam int L8 = 536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.WAYS(4)) b4 ();
    cache_ctrl_nway_if #(.WAYS(8)) b8 ();
    logic [31:0] hc4, mc4, wc4, hc8, mc8, wc8;

    cache_ctrl_nway #(.WAYS(4)) u4 (.clk(clk), .rst(rst), .bus(b4), .hit_count(hc4), .miss_count(mc4), .wb_count(wc4));
    cache_ctrl_nway #(.WAYS(8)) u8 (.clk(clk), .rst(rst), .bus(b8), .hit_count(hc8), .miss_count(mc8), .wb_count(wc8));

    int total = 0;
    int bad = 0;

    int           o_lat;
    logic [31:0]  o_dout, o_wb_addr, o_rf_addr;
    logic [7:0]   o_mask;
    logic         o_wb_seen, o_rf_seen;
    logic [511:0] o_wb_data;
    logic [4*L4-1:0] o_wr4;
    logic [8*L8-1:0] o_wr8;

    function automatic logic [511:0] mk_data(input logic [7:0] seed);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = {seed, 16'h0000, 8'(k)};
        return d;
    endfunction

    function automatic logic [L4-1:0] mk4(input logic v, input logic dt, input logic [1:0] a,
                                          input logic [18:0] t, input logic [511:0] dat);
        return {v, dt, a, t, dat};
    endfunction

    function automatic logic [L8-1:0] mk8(input logic v, input logic dt, input logic [2:0] a,
                                          input logic [18:0] t, input logic [511:0] dat);
        return {v, dt, a, t, dat};
    endfunction

    task automatic run4(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4*L4-1:0] lines, input logic [511:0] refill, input int mem_wait);
        int mw;
        bit done;
        mw = 0; done = 0; o_lat = 0; o_dout = '0; o_mask = '0; o_wr4 = '0;
        o_wb_seen = 0; o_rf_seen = 0; o_wb_addr = '0; o_rf_addr = '0; o_wb_data = '0;
        @(negedge clk);
        b4.cpu_req_enable = 1'b1; b4.cpu_req_rw = rw; b4.cpu_req_addr = addr; b4.cpu_req_datain = wdata;
        b4.cache_rd_lines = lines; b4.mem_req_datain = refill;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc == 1) b4.cpu_req_enable = 1'b0;
            b4.cache_ready = b4.cache_enable;
            if (b4.cache_enable && b4.cache_rw) begin
                o_wr4 = b4.cache_wr_lines; o_mask = {4'h0, b4.cache_wr_mask};
            end
            b4.mem_req_ready = 1'b0;
            if (b4.mem_req_enable) begin
                if (mw >= mem_wait) begin
                    b4.mem_req_ready = 1'b1; mw = 0;
                    if (b4.mem_req_rw) begin o_wb_seen = 1; o_wb_addr = b4.mem_req_addr; o_wb_data = b4.mem_req_dataout; end
                    else begin o_rf_seen = 1; o_rf_addr = b4.mem_req_addr; end
                end else mw++;
            end
            if (b4.cpu_res_ready) begin o_lat = cyc; o_dout = b4.cpu_res_dataout; done = 1; end
            @(negedge clk);
        end
        b4.cache_ready = 1'b0; b4.mem_req_ready = 1'b0;
    endtask

    task automatic run8(input logic [31:0] addr, input logic [8*L8-1:0] lines, input logic [511:0] refill);
        bit done;
        done = 0; o_lat = 0; o_wr8 = '0; o_wb_seen = 0; o_rf_seen = 0; o_rf_addr = '0;
        @(negedge clk);
        b8.cpu_req_enable = 1'b1; b8.cpu_req_rw = 1'b0; b8.cpu_req_addr = addr;
        b8.cache_rd_lines = lines; b8.mem_req_datain = refill;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc == 1) b8.cpu_req_enable = 1'b0;
            b8.cache_ready = b8.cache_enable;
            if (b8.cache_enable && b8.cache_rw) o_wr8 = b8.cache_wr_lines;
            b8.mem_req_ready = b8.mem_req_enable;
            if (b8.mem_req_enable && b8.mem_req_rw) o_wb_seen = 1;
            if (b8.mem_req_enable && !b8.mem_req_rw) begin o_rf_seen = 1; o_rf_addr = b8.mem_req_addr; end
            if (b8.cpu_res_ready) begin o_lat = cyc; done = 1; end
            @(negedge clk);
        end
        b8.cache_ready = 1'b0; b8.mem_req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (b4.cpu_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", b4.cpu_req_ready); end
        total++; if ({b4.cpu_res_ready, b4.cache_enable, b4.mem_req_enable, b4.cache_rw, b4.mem_req_rw, b4.cache_wr_mask} !== 9'h0) begin
            bad++; $display("FAIL reset_ctrl_outs: got %b want 0", {b4.cpu_res_ready, b4.cache_enable, b4.mem_req_enable, b4.cache_rw, b4.mem_req_rw, b4.cache_wr_mask}); end
        total++; if ({b4.cpu_res_dataout, b4.mem_req_addr, b4.cache_set} !== 71'h0) begin
            bad++; $display("FAIL reset_data_outs: got %h want 0", {b4.cpu_res_dataout, b4.mem_req_addr, b4.cache_set}); end
        total++; if ({hc4, mc4, wc4} !== 96'h0) begin bad++; $display("FAIL reset_counters: got %h want 0", {hc4, mc4, wc4}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_read_hit();
        logic [4*L4-1:0] ln;
        ln = {mk4(1, 0, 2'd2, 19'd3, mk_data(8'h13)), mk4(1, 0, 2'd1, 19'd2, mk_data(8'h12)),
              mk4(1, 0, 2'd0, 19'd0, mk_data(8'h11)), mk4(1, 0, 2'd3, 19'd1, mk_data(8'h10))};
        run4(1'b0, 32'h0000_0ABC, 32'h0, ln, '0, 0);
        total++; if (o_lat !== 4) begin bad++; $display("FAIL hit_latency: got %0d want 4", o_lat); end
        total++; if (hc4 !== 32'd1) begin bad++; $display("FAIL hit_count: got %0d want 1", hc4); end
        total++; if (o_dout !== 32'h1100_000F) begin bad++; $display("FAIL hit_dout: got %h want 1100000f", o_dout); end
        total++; if (o_mask !== 8'h0F) begin bad++; $display("FAIL hit_mask: got %h want 0f", o_mask); end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_wr4[i*L4 +: L4] !== ln[i*L4 +: L4]) begin
                bad++; $display("FAIL hit_line%0d: got %h want %h", i, o_wr4[i*L4 +: L4], ln[i*L4 +: L4]); end
        end
    endtask

    task automatic test_write_hit();
        logic [4*L4-1:0] ln, ex;
        logic [511:0] d2;
        d2 = mk_data(8'h22); d2[15*32 +: 32] = 32'hCAFE_BABE;
        ln = {mk4(1, 0, 2'd3, 19'd4, mk_data(8'h23)), mk4(1, 0, 2'd2, 19'd0, mk_data(8'h22)),
              mk4(1, 0, 2'd1, 19'd3, mk_data(8'h21)), mk4(1, 0, 2'd0, 19'd1, mk_data(8'h20))};
        ex = {mk4(1, 0, 2'd3, 19'd4, mk_data(8'h23)), mk4(1, 1, 2'd0, 19'd0, d2),
              mk4(1, 0, 2'd2, 19'd3, mk_data(8'h21)), mk4(1, 0, 2'd1, 19'd1, mk_data(8'h20))};
        run4(1'b1, 32'h0000_0ABC, 32'hCAFE_BABE, ln, '0, 0);
        total++; if (o_lat !== 4) begin bad++; $display("FAIL whit_latency: got %0d want 4", o_lat); end
        total++; if ({hc4, mc4} !== {32'd2, 32'd0}) begin bad++; $display("FAIL whit_counts: got %0d/%0d want 2/0", hc4, mc4); end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_wr4[i*L4 +: L4] !== ex[i*L4 +: L4]) begin
                bad++; $display("FAIL whit_line%0d: got %h want %h", i, o_wr4[i*L4 +: L4], ex[i*L4 +: L4]); end
        end
    endtask

    task automatic test_clean_miss();
        logic [4*L4-1:0] ln, ex;
        logic [511:0] r;
        r = mk_data(8'hAA);
        ln = {mk4(1, 0, 2'd3, 19'd3, mk_data(8'h33)), mk4(1, 0, 2'd2, 19'd2, mk_data(8'h32)),
              mk4(1, 0, 2'd1, 19'd1, mk_data(8'h31)), mk4(0, 0, 2'd0, 19'd7, mk_data(8'h30))};
        ex = {mk4(1, 0, 2'd3, 19'd3, mk_data(8'h33)), mk4(1, 0, 2'd3, 19'd2, mk_data(8'h32)),
              mk4(1, 0, 2'd2, 19'd1, mk_data(8'h31)), mk4(1, 0, 2'd0, 19'd0, r)};
        run4(1'b0, 32'h0000_0ABC, 32'h0, ln, r, 0);
        total++; if (o_lat !== 5) begin bad++; $display("FAIL cmiss_latency: got %0d want 5", o_lat); end
        total++; if (o_wb_seen !== 1'b0) begin bad++; $display("FAIL cmiss_no_wb: got %b want 0", o_wb_seen); end
        total++; if ({o_rf_seen, o_rf_addr} !== {1'b1, 32'h0000_0A80}) begin bad++; $display("FAIL cmiss_rf_addr: got %b/%h want 1/00000a80", o_rf_seen, o_rf_addr); end
        total++; if ({mc4, wc4} !== {32'd1, 32'd0}) begin bad++; $display("FAIL cmiss_counts: got %0d/%0d want 1/0", mc4, wc4); end
        total++; if (o_dout !== 32'hAA00_000F) begin bad++; $display("FAIL cmiss_dout: got %h want aa00000f", o_dout); end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_wr4[i*L4 +: L4] !== ex[i*L4 +: L4]) begin
                bad++; $display("FAIL cmiss_line%0d: got %h want %h", i, o_wr4[i*L4 +: L4], ex[i*L4 +: L4]); end
        end
    endtask

    task automatic test_dirty_miss();
        logic [4*L4-1:0] ln, ex;
        logic [511:0] r, rm;
        r = mk_data(8'hBB); rm = r; rm[15*32 +: 32] = 32'h1234_5678;
        ln = {mk4(1, 1, 2'd3, 19'd5, mk_data(8'h43)), mk4(1, 0, 2'd2, 19'd3, mk_data(8'h42)),
              mk4(1, 0, 2'd0, 19'd2, mk_data(8'h41)), mk4(1, 0, 2'd1, 19'd1, mk_data(8'h40))};
        ex = {mk4(1, 1, 2'd0, 19'd0, rm), mk4(1, 0, 2'd3, 19'd3, mk_data(8'h42)),
              mk4(1, 0, 2'd1, 19'd2, mk_data(8'h41)), mk4(1, 0, 2'd2, 19'd1, mk_data(8'h40))};
        run4(1'b1, 32'h0000_0ABC, 32'h1234_5678, ln, r, 1);
        total++; if (o_lat !== 8) begin bad++; $display("FAIL dmiss_latency: got %0d want 8", o_lat); end
        total++; if ({o_wb_seen, o_wb_addr} !== {1'b1, 32'h0000_AA80}) begin bad++; $display("FAIL dmiss_wb_addr: got %b/%h want 1/0000aa80", o_wb_seen, o_wb_addr); end
        total++; if (o_wb_data !== mk_data(8'h43)) begin bad++; $display("FAIL dmiss_wb_data: got %h want %h", o_wb_data, mk_data(8'h43)); end
        total++; if ({o_rf_seen, o_rf_addr} !== {1'b1, 32'h0000_0A80}) begin bad++; $display("FAIL dmiss_rf_addr: got %b/%h want 1/00000a80", o_rf_seen, o_rf_addr); end
        total++; if ({mc4, wc4} !== {32'd2, 32'd1}) begin bad++; $display("FAIL dmiss_counts: got %0d/%0d want 2/1", mc4, wc4); end
        for (int i = 0; i < 4; i++) begin
            total++; if (o_wr4[i*L4 +: L4] !== ex[i*L4 +: L4]) begin
                bad++; $display("FAIL dmiss_line%0d: got %h want %h", i, o_wr4[i*L4 +: L4], ex[i*L4 +: L4]); end
        end
    endtask

    task automatic test_reset_in_refill();
        logic [4*L4-1:0] ln;
        bit seen;
        seen = 0;
        ln = {mk4(1, 0, 2'd3, 19'd3, mk_data(8'h53)), mk4(1, 0, 2'd2, 19'd2, mk_data(8'h52)),
              mk4(1, 0, 2'd1, 19'd1, mk_data(8'h51)), mk4(0, 0, 2'd0, 19'd7, mk_data(8'h50))};
        @(negedge clk);
        b4.cpu_req_enable = 1'b1; b4.cpu_req_rw = 1'b0; b4.cpu_req_addr = 32'h0000_0ABC;
        b4.cache_rd_lines = ln; b4.mem_req_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            b4.cpu_req_enable = 1'b0;
            b4.cache_ready = b4.cache_enable;
            if (b4.mem_req_enable && !b4.mem_req_rw) seen = 1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_refill_reached: got %b want 1", seen); end
        total++; if (mc4 !== 32'd3) begin bad++; $display("FAIL rst_pre_miss_count: got %0d want 3", mc4); end
        b4.cache_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({b4.mem_req_enable, b4.cpu_req_ready} !== 2'b01) begin bad++; $display("FAIL rst_refill_state: got mem_en=%b req_ready=%b want 0/1", b4.mem_req_enable, b4.cpu_req_ready); end
        total++; if ({hc4, mc4, wc4} !== 96'h0) begin bad++; $display("FAIL rst_refill_counters: got %h want 0", {hc4, mc4, wc4}); end
        ln = {mk4(1, 0, 2'd2, 19'd3, mk_data(8'h13)), mk4(1, 0, 2'd1, 19'd2, mk_data(8'h12)),
              mk4(1, 0, 2'd0, 19'd0, mk_data(8'h11)), mk4(1, 0, 2'd3, 19'd1, mk_data(8'h10))};
        run4(1'b0, 32'h0000_0ABC, 32'h0, ln, '0, 0);
        total++; if ({o_lat, hc4} !== {32'd4, 32'd1}) begin bad++; $display("FAIL rst_recover_hit: got lat=%0d hits=%0d want 4/1", o_lat, hc4); end
    endtask

    task automatic test_eight_way_miss();
        logic [8*L8-1:0] ln, ex;
        logic [2:0] old_age [8];
        logic [2:0] new_age [8];
        logic [511:0] r;
        r = mk_data(8'hCC);
        old_age = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        new_age = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 8; i++) begin
            ln[i*L8 +: L8] = mk8(1, 0, old_age[i], 19'(i + 1), mk_data(8'(8'h60 + i)));
            ex[i*L8 +: L8] = (i == 4) ? mk8(1, 0, 3'd0, 19'd0, r) : mk8(1, 0, new_age[i], 19'(i + 1), mk_data(8'(8'h60 + i)));
        end
        run8(32'h0000_0ABC, ln, r);
        total++; if (o_lat !== 5) begin bad++; $display("FAIL w8_latency: got %0d want 5", o_lat); end
        total++; if ({o_wb_seen, o_rf_seen, o_rf_addr} !== {2'b01, 32'h0000_0A80}) begin bad++; $display("FAIL w8_mem: got wb=%b rf=%b addr=%h want 0/1/00000a80", o_wb_seen, o_rf_seen, o_rf_addr); end
        total++; if ({hc8, mc8, wc8} !== {32'd0, 32'd1, 32'd0}) begin bad++; $display("FAIL w8_counts: got %0d/%0d/%0d want 0/1/0", hc8, mc8, wc8); end
        for (int i = 0; i < 8; i++) begin
            total++; if (o_wr8[i*L8 +: L8] !== ex[i*L8 +: L8]) begin
                bad++; $display("FAIL w8_line%0d: got %h want %h", i, o_wr8[i*L8 +: L8], ex[i*L8 +: L8]); end
        end
    endtask

    initial begin
        b4.cpu_req_enable = 1'b0; b4.cpu_req_rw = 1'b0; b4.cpu_req_addr = '0; b4.cpu_req_datain = '0;
        b4.cache_ready = 1'b0; b4.cache_rd_lines = '0; b4.mem_req_datain = '0; b4.mem_req_ready = 1'b0;
        b8.cpu_req_enable = 1'b0; b8.cpu_req_rw = 1'b0; b8.cpu_req_addr = '0; b8.cpu_req_datain = '0;
        b8.cache_ready = 1'b0; b8.cache_rd_lines = '0; b8.mem_req_datain = '0; b8.mem_req_ready = 1'b0;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_reset_in_refill();
        test_eight_way_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
